// File: rtl/clock_rate_controller.sv
// Programmable clock divider with a two-requester, round-robin rate-change port.
// New divisors are staged and only applied on a period boundary.
module clock_rate_controller #(
   parameter int unsigned DIV_WIDTH   = 19,
   parameter int unsigned DEFAULT_DIV = 500
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           req_valid,
   input  logic [DIV_WIDTH-1:0] req_div0,
   input  logic [DIV_WIDTH-1:0] req_div1,
   output logic [1:0]           req_ready,
   output logic                 grant_id,
   output logic                 busy,
   output logic [DIV_WIDTH-1:0] cur_div,
   output logic                 tick,
   output logic                 newClock
);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_e;

   localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

   state_e               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] pend_q, pend_d;
   logic                 ptr_q, ptr_d;
   logic                 gid_q, gid_d;

   logic                 last;
   logic                 win;
   logic [DIV_WIDTH-1:0] win_div;
   logic [DIV_WIDTH-1:0] win_clamp;

   assign last     = (cnt_q == (div_q - ONE));
   assign tick     = last;
   assign newClock = (cnt_q >= (div_q >> 1));
   assign cur_div  = div_q;
   assign grant_id = gid_q;

   // Contention goes to the pointer; a lone requester wins outright.
   assign win       = (&req_valid) ? ptr_q : req_valid[1];
   assign win_div   = win ? req_div1 : req_div0;
   assign win_clamp = (win_div < MIN_DIV) ? MIN_DIV : win_div;

   always_comb begin
      state_d   = state_q;
      cnt_d     = last ? '0 : (cnt_q + ONE);
      div_d     = div_q;
      pend_d    = pend_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      req_ready = 2'b00;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            if ((|req_valid) && !reset) begin
               req_ready = win ? 2'b10 : 2'b01;
               pend_d    = win_clamp;
               gid_d     = win;
               ptr_d     = ~win;
               state_d   = PENDING;
            end
         end
         PENDING: begin
            busy = 1'b1;
            if (last) begin
               div_d   = pend_q;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= DEF_DIV;
         pend_q  <= '0;
         ptr_q   <= 1'b0;
         gid_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
      end
   end

endmodule

// File: doc/clock_rate_controller.md
CLOCK_RATE_CONTROLLER -- requirements
Module: clock_rate_controller

Interface
REQ-001 Parameter DIV_WIDTH, default 19: width of all divisor and counter values.
REQ-002 Parameter DEFAULT_DIV, default 500: divisor loaded at reset (50 MHz / 500 = 100 kHz).
REQ-003 clock  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 req_valid  input  2  per-requester rate-change request; bit i belongs to requester i.
REQ-006 req_div0  input  DIV_WIDTH  divisor requested by requester 0; held stable while req_valid[0]=1.
REQ-007 req_div1  input  DIV_WIDTH  divisor requested by requester 1; held stable while req_valid[1]=1.
REQ-008 req_ready  output  2  one-hot acceptance; transfer occurs on req_valid[i] & req_ready[i].
REQ-009 grant_id  output  1  index of most recently accepted requester.
REQ-010 busy  output  1  high while an accepted divisor awaits application.
REQ-011 cur_div  output  DIV_WIDTH  divisor currently in effect.
REQ-012 tick  output  1  one-cycle pulse on the last cycle of each output period.
REQ-013 newClock  output  1  divided square wave.

Function
REQ-014 Divisor D shall mean an output period of exactly D clock cycles; internal counter runs 0..D-1 then wraps to 0.
REQ-015 newClock shall be 0 while counter < floor(D/2), else 1 (combinational from counter and cur_div).
REQ-016 tick shall be 1 exactly in cycles where counter == cur_div-1.
REQ-017 FSM states: IDLE, PENDING; reset state IDLE.
REQ-018 IDLE: if any req_valid bit is set, exactly one req_ready bit shall assert in that same cycle (combinational), the winner's divisor latched into pending register at the edge, grant_id updated, next state PENDING.
REQ-019 Arbitration: round-robin; single valid wins outright; both valid -> requester named by priority pointer wins; pointer then points to the other requester.
REQ-020 PENDING: req_ready shall be 00; busy=1; at the edge where counter == cur_div-1, cur_div <= pending, counter <= 0, state <= IDLE.
REQ-021 New divisor shall never take effect mid-period; no shortened or stretched high/low phase within a period.
REQ-022 Accepted divisor < 2 shall be clamped to 2; divisor of all-ones is legal.
REQ-023 Request equal to cur_div shall still pass through PENDING and apply at next wrap (no special case).
REQ-024 A request accepted in the cycle where counter == cur_div-1 shall apply at the following wrap, not the current one.
REQ-025 Unselected requester keeps req_valid asserted; it is served in a later IDLE cycle; no request is dropped.
REQ-026 Counter width DIV_WIDTH; counter shall never exceed cur_div-1.

Reset
REQ-027 On reset=1 at an edge: counter=0, cur_div=DEFAULT_DIV, state=IDLE, priority pointer=0, grant_id=0, pending cleared.
REQ-028 Outputs during/after reset: req_ready=00, busy=0, tick=0, newClock=0 (given DEFAULT_DIV >= 2).
REQ-029 Reset mid-PENDING shall discard the pending divisor; reset has priority over all other events.

Verification (bench uses DEFAULT_DIV=4)
REQ-030 Reset released, no requests -> newClock 0,0,1,1 repeating; tick high at counter=3 every 4th cycle; cur_div=4.
REQ-031 req_valid=01, req_div0=6 at counter=1 -> req_ready=01 that cycle, busy=1 through counter=3, then periods of 6 (newClock 0,0,0,1,1,1), busy=0, grant_id=0.
REQ-032 req_valid=11 (div0=6, div1=8) right after reset -> requester 0 granted first; after its apply, requester 1 granted next IDLE cycle; final cur_div=8, grant_id=1.
REQ-033 req_div0=1 accepted -> cur_div=2 after wrap; newClock alternates 0,1; tick every 2nd cycle.
REQ-034 reset pulsed while busy=1 with pending 6 -> cur_div=4, busy=0, counter=0, no later change to 6.
REQ-035 req_div1=5 -> newClock low 2 cycles, high 3 cycles per period; tick once per 5 cycles.
